// File: rtl/sonar_rx_pkg.sv
// Shared definitions for the sonar receive chain: detector FSM states,
// default tuning constants and a saturating absolute-value helper.
package sonar_rx_pkg;

    localparam int DEFAULT_K    = 3;
    localparam int DEFAULT_HITS = 2;
    localparam int RUN_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } det_state_e;

    // x is a sign-extended width-bit value; the most negative code maps to the most positive one.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] x, input int unsigned width);
        logic [63:0] mostNeg;
        mostNeg = (~64'd0) << (width - 1);
        if ($unsigned(x) == mostNeg)
            return (64'd1 << (width - 1)) - 64'd1;
        else if (x < 0)
            return $unsigned(-x);
        else
            return $unsigned(x);
    endfunction

endpackage

// File: rtl/echo_envelope_detector_if.sv
// Control/data bundle between the IIR stage, the register block and the
// echo envelope detector.
interface echo_envelope_detector_if #(
    parameter int N  = 16,
    parameter int CW = 16
);
    logic                  start;
    logic                  y_valid;
    logic signed [2*N-1:0] y_in;
    logic [2*N-1:0]        threshold;
    logic [CW-1:0]         blank_samples;
    logic [CW-1:0]         max_samples;
    logic                  busy;
    logic                  done;
    logic                  hit;
    logic [CW-1:0]         tof;
    logic [2*N-1:0]        peak;

    modport master (
        output start, y_valid, y_in, threshold, blank_samples, max_samples,
        input  busy, done, hit, tof, peak
    );

    modport slave (
        input  start, y_valid, y_in, threshold, blank_samples, max_samples,
        output busy, done, hit, tof, peak
    );
endinterface

// File: rtl/echo_envelope.sv
// Rectifier plus leaky-integrator envelope: env += (|y| - env) / 2^K,
// with the next value exposed combinationally for the compare logic.
module echo_envelope
    import sonar_rx_pkg::*;
#(
    parameter int N = 16,
    parameter int K = DEFAULT_K
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic signed [2*N-1:0] y_i,
    output logic [2*N-1:0]        env_next_o
);

    localparam int W = 2 * N;

    logic [W-1:0] env_q;
    logic [W-1:0] mag;

    // Subtracting env>>K before adding mag>>K keeps the sum below 2^W.
    always_comb begin
        mag        = W'(sat_abs({{(64-W){y_i[W-1]}}, y_i}, W));
        env_next_o = env_q - (env_q >> K) + (mag >> K);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            env_q <= '0;
        else if (clear_i)
            env_q <= '0;
        else if (en_i)
            env_q <= env_next_o;
    end

endmodule

// File: rtl/echo_envelope_detector.sv
// Echo detector: blanks the transmit ring-down, then reports the first
// sample where the envelope stays above threshold for HITS samples.
module echo_envelope_detector
    import sonar_rx_pkg::*;
#(
    parameter int N    = 16,
    parameter int CW   = 16,
    parameter int K    = DEFAULT_K,
    parameter int HITS = DEFAULT_HITS
) (
    input  logic                      clk,
    input  logic                      rst,
    echo_envelope_detector_if.slave   bus
);

    localparam int W = 2 * N;
    localparam logic [RUN_W-1:0] HITS_C = RUN_W'(HITS);

    det_state_e       state_q, state_d;
    logic [W-1:0]     thr_q, thr_d;
    logic [CW-1:0]    blank_q, blank_d;
    logic [CW-1:0]    max_q, max_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [W-1:0]     peak_q, peak_d;
    logic             hit_q, hit_d;
    logic [CW-1:0]    tof_q, tof_d;

    logic             envClear;
    logic             envEn;
    logic [W-1:0]     envNext;
    logic [RUN_W-1:0] runNext;
    logic             lastSample;

    echo_envelope #(.N(N), .K(K)) u_envelope (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (envClear),
        .en_i       (envEn),
        .y_i        (bus.y_in),
        .env_next_o (envNext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            thr_q   <= '0;
            blank_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            run_q   <= '0;
            peak_q  <= '0;
            hit_q   <= 1'b0;
            tof_q   <= '0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            blank_q <= blank_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            peak_q  <= peak_d;
            hit_q   <= hit_d;
            tof_q   <= tof_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        blank_d    = blank_q;
        max_d      = max_q;
        idx_d      = idx_q;
        run_d      = run_q;
        peak_d     = peak_q;
        hit_d      = hit_q;
        tof_d      = tof_q;
        envClear   = 1'b0;
        envEn      = 1'b0;
        runNext    = '0;
        lastSample = (idx_q == max_q - CW'(1));

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    envClear = 1'b1;
                    thr_d    = bus.threshold;
                    blank_d  = bus.blank_samples;
                    max_d    = bus.max_samples;
                    idx_d    = '0;
                    run_d    = '0;
                    peak_d   = '0;
                    hit_d    = 1'b0;
                    tof_d    = '0;
                    if (bus.max_samples == '0)
                        state_d = ST_DONE;
                    else if (bus.blank_samples == '0)
                        state_d = ST_LISTEN;
                    else
                        state_d = ST_BLANK;
                end
            end
            // A window shorter than the blanking period still times out here.
            ST_BLANK: begin
                if (bus.y_valid) begin
                    envEn = 1'b1;
                    idx_d = idx_q + CW'(1);
                    if (lastSample) begin
                        tof_d   = max_q;
                        state_d = ST_DONE;
                    end else if (idx_q == blank_q - CW'(1)) begin
                        state_d = ST_LISTEN;
                    end
                end
            end
            ST_LISTEN: begin
                if (bus.y_valid) begin
                    envEn = 1'b1;
                    idx_d = idx_q + CW'(1);
                    if (envNext > peak_q)
                        peak_d = envNext;
                    if (envNext >= thr_q)
                        runNext = (run_q == HITS_C) ? run_q : run_q + RUN_W'(1);
                    run_d = runNext;
                    if (runNext == HITS_C) begin
                        hit_d   = 1'b1;
                        tof_d   = idx_q;
                        state_d = ST_DONE;
                    end else if (lastSample) begin
                        tof_d   = max_q;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == ST_BLANK) || (state_q == ST_LISTEN);
        bus.done = (state_q == ST_DONE);
        bus.hit  = hit_q;
        bus.tof  = tof_q;
        bus.peak = peak_q;
    end

endmodule
